instruction_cache: RTL



---
 rtl/instruction_cache_if.sv | 23 ++
 rtl/instruction_cache.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/instruction_cache_if.sv
// DDR read port between the instruction cache (master) and the DDR controller (slave).
// One request is outstanding at a time; ddr_addr is a byte address.
`timescale 1ns/1ps
interface instruction_cache_if #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int INS_WIDTH      = 64
);
  logic                      ddr_rd_en;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr;
  logic                      ddr_rdy;
  logic [INS_WIDTH-1:0]      ddr_rd_data;
  logic                      ddr_rd_data_valid;

  modport master (
    output ddr_rd_en, ddr_addr,
    input  ddr_rdy, ddr_rd_data, ddr_rd_data_valid
  );

  modport slave (
    input  ddr_rd_en, ddr_addr,
    output ddr_rdy, ddr_rd_data, ddr_rd_data_valid
  );
endinterface

// File: rtl/instruction_cache.sv
// Block-based instruction cache: loads ISA_DEPTH instructions of one program block from DDR,
// then serves instructions from that block with one-cycle latency until the PC leaves it.
`timescale 1ns/1ps
module instruction_cache #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int INS_WIDTH       = 64,
  parameter int ISA_BASE_ADDR   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      ins_cache_rdy,
  output logic [3:0]                st_cur_ins_cache,
  output logic [9:0]                load_times,
  output logic [INS_WIDTH-1:0]      ins_out,
  output logic                      ins_valid,
  instruction_cache_if.master       ddr
);
  localparam int LG = $clog2(ISA_DEPTH);

  // state    | meaning
  // START    | after reset, kick off load of block 0
  // LOAD_INS | fetching ISA_DEPTH words of target block, one read outstanding
  // SENT_INS | block resident, serving instructions in its window
  typedef enum logic [3:0] {START = 4'd1, LOAD_INS = 4'd2, SENT_INS = 4'd3} state_t;

  state_t                    state_q, state_d;
  logic [9:0]                blk_q, blk_d, load_times_q, load_times_d;
  logic [LG-1:0]             k_q, k_d;
  logic                      pend_q, pend_d, rd_en_q, rd_en_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INS_WIDTH-1:0]      ins_out_q, ins_out_d;
  logic                      ins_valid_q, ins_valid_d;
  logic [INS_WIDTH-1:0]      mem_q [ISA_DEPTH];
  logic                      mem_we;
  logic [31:0]               a_ext, win_hi, win_lo;
  logic [9:0]                new_blk;
  logic                      a_jmp, a_over, a_in_win, rd_done, last_word;

  function automatic logic [DDR_ADDR_WIDTH-1:0] word_addr(input logic [9:0] blk,
                                                          input logic [LG-1:0] k);
    logic [DDR_ADDR_WIDTH-1:0] idx;
    idx = (DDR_ADDR_WIDTH'(blk) << LG) | DDR_ADDR_WIDTH'(k);
    return DDR_ADDR_WIDTH'(ISA_BASE_ADDR) + (idx << 3);
  endfunction

  assign a_ext     = 32'(addr_ins);
  assign win_hi    = 32'(load_times_q) << LG;
  assign win_lo    = win_hi - 32'(ISA_DEPTH);
  assign a_jmp     = addr_ins[ADDR_WIDTH_MEM-1];
  assign a_over    = a_ext >= 32'(TOTAL_ISA_DEPTH);
  assign a_in_win  = (a_ext >= win_lo) && (a_ext < win_hi);
  // Sequential fall-through (addr == window end) yields block load_times here too.
  assign new_blk   = 10'(a_ext >> LG);
  assign rd_done   = pend_q && ddr.ddr_rd_data_valid;
  assign last_word = (k_q == LG'(ISA_DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= START;
      blk_q        <= '0;
      load_times_q <= '0;
      k_q          <= '0;
      pend_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      ins_out_q    <= '0;
      ins_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      load_times_q <= load_times_d;
      k_q          <= k_d;
      pend_q       <= pend_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      ins_out_q    <= ins_out_d;
      ins_valid_q  <= ins_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[k_q] <= ddr.ddr_rd_data;
  end

  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      START:    state_d = LOAD_INS;
      LOAD_INS: if (rd_done && last_word) state_d = SENT_INS;
      SENT_INS: if (!a_jmp && !a_over && !a_in_win) state_d = LOAD_INS;
      default:  state_d = START;
    endcase
  end

  always_comb begin : output_comb
    ins_cache_rdy = (state_q == SENT_INS);
    blk_d         = blk_q;
    k_d           = k_q;
    pend_d        = pend_q;
    rd_en_d       = rd_en_q;
    addr_d        = addr_q;
    load_times_d  = load_times_q;
    ins_out_d     = ins_out_q;
    ins_valid_d   = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      START: begin
        blk_d   = '0;
        k_d     = '0;
        pend_d  = 1'b0;
        rd_en_d = 1'b1;
        addr_d  = word_addr('0, '0);
      end
      LOAD_INS: begin
        if (rd_en_q && ddr.ddr_rdy) begin
          rd_en_d = 1'b0;
          pend_d  = 1'b1;
        end
        if (rd_done) begin
          mem_we = 1'b1;
          pend_d = 1'b0;
          k_d    = k_q + LG'(1);
          if (last_word) begin
            load_times_d = blk_q + 10'd1;
          end else begin
            rd_en_d = 1'b1;
            addr_d  = word_addr(blk_q, k_q + LG'(1));
          end
        end
      end
      SENT_INS: begin
        if (!a_jmp && !a_over) begin
          if (a_in_win) begin
            ins_out_d   = mem_q[a_ext[LG-1:0]];
            ins_valid_d = 1'b1;
          end else begin
            blk_d   = new_blk;
            k_d     = '0;
            pend_d  = 1'b0;
            rd_en_d = 1'b1;
            addr_d  = word_addr(new_blk, '0);
          end
        end
      end
      default: begin
        rd_en_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign st_cur_ins_cache = state_q;
  assign load_times       = load_times_q;
  assign ins_out          = ins_out_q;
  assign ins_valid        = ins_valid_q;
  assign ddr.ddr_rd_en    = rd_en_q;
  assign ddr.ddr_addr     = addr_q;
endmodule
